fpu_resp_buffer: RTL and testbench
==================================

FPU_RESP_BUFFER -- requirements
Module: fpu_resp_buffer

Interface
REQ-001 SHALL have parameter FLEN, default 32, the result width.
REQ-002 SHALL have parameter TAG_WIDTH, default 2, the tag width.
REQ-003 SHALL have parameter DEPTH, default 4, the number of FIFO entries (power of two, 2 or more).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port issue_fire_i, input, 1 bit: an op entered the FPU this cycle (in_valid AND in_ready).
REQ-007 SHALL have port issue_allow_o, output, 1 bit: a credit is free; upstream may issue.
REQ-008 SHALL have port fpu_valid_i, input, 1 bit: the FPU out_valid.
REQ-009 SHALL have port fpu_ready_o, output, 1 bit: drives the FPU out_ready.
REQ-010 SHALL have port fpu_result_i, input, FLEN bits: the FPU result.
REQ-011 SHALL have port fpu_status_i, input, 5 bits: FPU status {NV,DZ,OF,UF,NX}.
REQ-012 SHALL have port fpu_tag_i, input, TAG_WIDTH bits: the FPU tag.
REQ-013 SHALL have port deq_valid_o, input deq_ready_i, and outputs deq_result_o (FLEN), deq_status_o (5), deq_tag_o (TAG_WIDTH): the consumer valid/ready port.
REQ-014 SHALL have port flags_o, output, 5 bits: sticky OR of the status of every dequeued result.
REQ-015 SHALL have port flags_clr_i, input, 1 bit: clears flags_o.
REQ-016 SHALL have port flush_i, input, 1 bit: drops buffered data and credits; must be driven with the same signal as the FPU flush.
REQ-017 SHALL have port overflow_o, output, 1 bit: sticky error, set on a push while full.
REQ-018 SHALL have port count_o, output, $clog2(DEPTH+1) bits: the number of occupied entries.

Function
REQ-019 SHALL maintain credits_used, range 0..DEPTH: +1 on issue_fire_i, -1 on a deq handshake, unchanged when both occur in one cycle.
REQ-020 SHALL drive issue_allow_o = (credits_used < DEPTH), combinationally from the register.
REQ-021 SHALL ignore issue_fire_i when credits_used == DEPTH (no increment) and set overflow_o.
REQ-022 SHALL drive fpu_ready_o = NOT full; a push occurs on fpu_valid_i AND fpu_ready_o.
REQ-023 SHALL store {result, status, tag} in a circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-024 SHALL present deq_valid_o one cycle after the push edge; the first word has no combinational FPU-to-deq path.
REQ-025 SHALL drive deq_* from the head entry; deq_result_o, deq_status_o and deq_tag_o hold stable while deq_valid_o=1 and deq_ready_i=0.
REQ-026 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-027 SHALL block the push when full (count == DEPTH) because fpu_ready_o=0; the FPU stalls.
REQ-028 SHALL set overflow_o, and never clear it except by reset, on an issue_fire_i at full credits or on a push seen while full.
REQ-029 SHALL, on a deq handshake, update flags_o <= (flags_clr_i ? 0 : flags_o) | deq_status_o; a clear in the same cycle does not lose the new flags.
REQ-030 SHALL, on flush_i, set both pointers, count and credits_used to 0, drop any same-cycle push and issue, and leave flags_o unchanged.
REQ-031 SHALL, the cycle after flush_i, drive deq_valid_o=0 and issue_allow_o=1.

Reset
REQ-032 SHALL, while rst_ni=0, asynchronously force pointers=0, count=0, credits_used=0, flags_o=0, overflow_o=0.
REQ-033 SHALL therefore hold deq_valid_o=0, fpu_ready_o=1 and issue_allow_o=1 in reset.
REQ-034 SHALL not reset FIFO data storage; deq_* data is don't-care while deq_valid_o=0.
REQ-035 SHALL, on reset mid-operation, discard all entries; no deq handshake occurs in the cycle reset releases.

Structure
REQ-036 SHALL place the status bit-index constants (NV=4, DZ=3, OF=2, UF=1, NX=0) and the entry struct typedef in shared package fpu_resp_pkg.
REQ-037 SHALL use one natural sub-module, fpu_resp_fifo (storage plus pointers); credits, flags and overflow stay in the top.

Verification
REQ-038 SHALL cover: reset, then push result 0x3F800000, tag 1, status 0 -> deq_valid_o=1 next cycle; data and tag match; count_o=1.
REQ-039 SHALL cover: DEPTH=4, 4 issues then 4 pushes, deq_ready_i=0 -> issue_allow_o=0, fpu_ready_o=0, count_o=4; a 5th issue sets overflow_o.
REQ-040 SHALL cover: full FIFO, deq_ready_i=1 for 4 cycles -> results emerge in push order with tags 0,1,2,3; issue_allow_o returns to 1 after the first pop.
REQ-041 SHALL cover: dequeue status 5'b00001, then 5'b10000 with flags_clr_i=1 in the same cycle -> flags_o=5'b10000.
REQ-042 SHALL cover: 2 entries buffered, flush_i with a simultaneous push -> next cycle count_o=0, deq_valid_o=0, issue_allow_o=1, flags_o unchanged.
REQ-043 SHALL cover: assert rst_ni=0 asynchronously mid-burst -> all outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/fpu_resp_pkg.sv
// Shared definitions for the FPU response buffer.
// Contents:
//   - bit positions of the IEEE status flags inside the 5-bit status word
//   - status_t, the 5-bit status word {NV,DZ,OF,UF,NX}
//   - resp_entry_t, one buffered response {result, status, tag} at the
//     default geometry (32-bit result, 2-bit tag); the top builds the same
//     layout at its own FLEN/TAG_WIDTH and hands it to the FIFO.
package fpu_resp_pkg;

  localparam int unsigned STATUS_W = 5;

  localparam int unsigned ST_NV = 4;  // invalid operation
  localparam int unsigned ST_DZ = 3;  // divide by zero
  localparam int unsigned ST_OF = 2;  // overflow
  localparam int unsigned ST_UF = 1;  // underflow
  localparam int unsigned ST_NX = 0;  // inexact

  typedef logic [STATUS_W-1:0] status_t;

  typedef struct packed {
    logic [31:0] result;
    status_t     status;
    logic [1:0]  tag;
  } resp_entry_t;

endpackage

// File: rtl/fpu_resp_fifo.sv
// Circular FIFO holding FPU responses.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (pointers/count only)
//   flush_i         empties the FIFO; overrides a same-cycle push/pop
//   push_i, wdata_i write an entry (ignored while full)
//   pop_i           retire the head entry (ignored while empty)
//   rdata_o         head entry, read straight from storage so it is stable
//                   for as long as the head does not move
//   count_o, full_o, empty_o  occupancy
// Storage is not reset; its content is meaningless while empty_o=1.
import fpu_resp_pkg::*;

module fpu_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fpu_resp_pkg::resp_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           wdata_i,
  input  logic             pop_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_resp_buffer.sv
// Credit-based response buffer between an FPU and its consumer.
// Upstream may only issue while a credit is free, so every op in flight
// is guaranteed a FIFO slot when its result comes back.
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   issue_fire_i, issue_allow_o  op accepted by the FPU / credit available
//   fpu_valid_i, fpu_ready_o     FPU result handshake
//   fpu_result_i/status_i/tag_i  FPU result payload
//   deq_valid_o, deq_ready_i     consumer handshake
//   deq_result_o/status_o/tag_o  head-of-FIFO payload
//   flags_o, flags_clr_i         sticky OR of dequeued status / clear
//   flush_i                      drop buffered results and credits
//   overflow_o                   sticky protocol-error flag
//   count_o                      FIFO occupancy
import fpu_resp_pkg::*;

module fpu_resp_buffer #(
  parameter int unsigned FLEN      = 32,
  parameter int unsigned TAG_WIDTH = 2,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_fire_i,
  output logic                 issue_allow_o,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [TAG_WIDTH-1:0] fpu_tag_i,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  output logic [FLEN-1:0]      deq_result_o,
  output logic [4:0]           deq_status_o,
  output logic [TAG_WIDTH-1:0] deq_tag_o,
  output logic [4:0]           flags_o,
  input  logic                 flags_clr_i,
  input  logic                 flush_i,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     count_o
);

  typedef struct packed {
    logic [FLEN-1:0]      result;
    status_t              status;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t           wr_entry, head;
  logic             fifo_full, fifo_empty;
  logic             push, pop, issue_ok, credit_ret;
  logic [CNT_W-1:0] credits_q, credits_d;
  status_t          flags_q, flags_d;
  logic             overflow_q, overflow_d;

  assign wr_entry = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};

  fpu_resp_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .push_i (push),
    .wdata_i(wr_entry),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(count_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign fpu_ready_o   = !fifo_full;
  assign push          = fpu_valid_i && !fifo_full && !flush_i;
  assign deq_valid_o   = !fifo_empty;
  // A flush squashes a coincident dequeue so nothing leaks into flags/credits.
  assign pop           = deq_valid_o && deq_ready_i && !flush_i;
  assign issue_allow_o = (credits_q < CNT_W'(DEPTH));
  assign issue_ok      = issue_fire_i && issue_allow_o;
  // Never return a credit that was not taken (guards against a stray push).
  assign credit_ret    = pop && (credits_q != '0);

  assign deq_result_o  = head.result;
  assign deq_status_o  = head.status;
  assign deq_tag_o     = head.tag;
  assign flags_o       = flags_q;
  assign overflow_o    = overflow_q;

  always_comb begin
    credits_d  = credits_q;
    flags_d    = flags_q;
    overflow_d = overflow_q;
    // Issue without a credit, or a result arriving with no room, means
    // upstream broke the credit contract.
    if ((issue_fire_i && !issue_allow_o) || (fpu_valid_i && fifo_full)) begin
      overflow_d = 1'b1;
    end
    if (flush_i) begin
      credits_d = '0;
    end else begin
      if (issue_ok && !credit_ret) credits_d = credits_q + CNT_W'(1);
      else if (!issue_ok && credit_ret) credits_d = credits_q - CNT_W'(1);
      // Clear and accumulate in one cycle keeps the newly dequeued status.
      if (pop) flags_d = (flags_clr_i ? '0 : flags_q) | head.status;
      else if (flags_clr_i) flags_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q  <= '0;
      flags_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      flags_q    <= flags_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fpu_resp_buffer.sv
module tb_fpu_resp_buffer;

  localparam int FLEN = 32;
  localparam int TW   = 2;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_fire_i, issue_allow_o;
  logic            fpu_valid_i, fpu_ready_o;
  logic [FLEN-1:0] fpu_result_i;
  logic [4:0]      fpu_status_i;
  logic [TW-1:0]   fpu_tag_i;
  logic            deq_valid_o, deq_ready_i;
  logic [FLEN-1:0] deq_result_o;
  logic [4:0]      deq_status_o;
  logic [TW-1:0]   deq_tag_o;
  logic [4:0]      flags_o;
  logic            flags_clr_i, flush_i, overflow_o;
  logic [2:0]      count_o;

  fpu_resp_buffer #(.FLEN(FLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_fire_i(issue_fire_i), .issue_allow_o(issue_allow_o),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_result_o(deq_result_o), .deq_status_o(deq_status_o), .deq_tag_o(deq_tag_o),
    .flags_o(flags_o), .flags_clr_i(flags_clr_i), .flush_i(flush_i),
    .overflow_o(overflow_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [FLEN-1:0] r;
    logic [4:0]      s;
    logic [TW-1:0]   t;
  } exp_t;

  // Reference model: FIFO content as a queue, credits as a plain counter.
  exp_t       mq[$];
  int         m_cred  = 0;
  logic [4:0] m_flags = '0;
  logic       m_ovf   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor + scoreboard: sample mid-cycle, compare against the model,
  // then advance the model by what the coming rising edge will commit.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mq.delete();
      m_cred  = 0;
      m_flags = '0;
      m_ovf   = 1'b0;
      chk("rst_deq_valid", 64'(deq_valid_o), 64'(0));
      chk("rst_fpu_ready", 64'(fpu_ready_o), 64'(1));
      chk("rst_issue_allow", 64'(issue_allow_o), 64'(1));
    end else begin
      automatic int   sz      = mq.size();
      automatic int   cred0   = m_cred;
      automatic logic hs      = (sz > 0) && deq_ready_i && !flush_i;
      automatic logic issue_k = issue_fire_i && (cred0 < DEPTH);
      chk("count", 64'(count_o), 64'(sz));
      chk("deq_valid", 64'(deq_valid_o), 64'(sz > 0));
      chk("fpu_ready", 64'(fpu_ready_o), 64'(sz < DEPTH));
      chk("issue_allow", 64'(issue_allow_o), 64'(cred0 < DEPTH));
      chk("flags", 64'(flags_o), 64'(m_flags));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      if (sz > 0) begin
        chk("deq_result", 64'(deq_result_o), 64'(mq[0].r));
        chk("deq_status", 64'(deq_status_o), 64'(mq[0].s));
        chk("deq_tag", 64'(deq_tag_o), 64'(mq[0].t));
      end
      if ((issue_fire_i && cred0 == DEPTH) || (fpu_valid_i && sz == DEPTH)) m_ovf = 1'b1;
      if (flush_i) begin
        mq.delete();
        m_cred = 0;
      end else begin
        if (hs) begin
          $display("DEQ tag=%0d result=%08h status=%05b", mq[0].t, mq[0].r, mq[0].s);
          m_flags = (flags_clr_i ? 5'b0 : m_flags) | mq[0].s;
          void'(mq.pop_front());
        end else if (flags_clr_i) begin
          m_flags = '0;
        end
        if (fpu_valid_i && sz < DEPTH) mq.push_back('{fpu_result_i, fpu_status_i, fpu_tag_i});
        m_cred = cred0 + (issue_k ? 1 : 0) - ((hs && cred0 > 0) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_fire_i = 0; fpu_valid_i = 0; deq_ready_i = 0;
    flags_clr_i = 0; flush_i = 0;
    fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
  endtask

  task automatic push(input logic [FLEN-1:0] r, input logic [4:0] s, input logic [TW-1:0] t);
    fpu_valid_i = 1; fpu_result_i = r; fpu_status_i = s; fpu_tag_i = t;
    tick();
    fpu_valid_i = 0;
  endtask

  task automatic issue(input int n);
    issue_fire_i = 1;
    repeat (n) tick();
    issue_fire_i = 0;
  endtask

  // One cycle of legal random traffic: the FPU only returns results for
  // ops that are in flight (issued, not yet buffered).
  task automatic rand_cycle();
    automatic int inflight = m_cred - mq.size();
    issue_fire_i = ($urandom_range(0, 2) == 0) && (m_cred < DEPTH);
    fpu_valid_i  = (inflight > 0) && ($urandom_range(0, 1) == 1);
    fpu_result_i = $urandom;
    fpu_status_i = 5'($urandom);
    fpu_tag_i    = TW'($urandom);
    deq_ready_i  = $urandom_range(0, 1) == 1;
    flags_clr_i  = $urandom_range(0, 9) == 0;
    flush_i      = $urandom_range(0, 59) == 0;
    tick();
  endtask

  initial begin
    idle();
    rst_ni = 0;
    repeat (3) tick();
    rst_ni = 1;
    tick();

    // First push appears one cycle after the push edge.
    issue(1);
    push(32'h3F800000, 5'b0, 2'd1);
    chk("first_valid", 64'(deq_valid_o), 64'(1));
    chk("first_result", 64'(deq_result_o), 64'h3F800000);
    chk("first_tag", 64'(deq_tag_o), 64'(1));
    chk("first_count", 64'(count_o), 64'(1));
    deq_ready_i = 1; tick(); deq_ready_i = 0;

    // Fill credits and FIFO, then over-issue.
    issue(4);
    for (int i = 0; i < 4; i++) push($urandom, 5'b0, TW'(i));
    chk("full_allow", 64'(issue_allow_o), 64'(0));
    chk("full_ready", 64'(fpu_ready_o), 64'(0));
    chk("full_count", 64'(count_o), 64'(4));
    issue(1);
    chk("over_issue", 64'(overflow_o), 64'(1));

    // Drain in order; a credit frees after the first pop.
    deq_ready_i = 1;
    tick();
    chk("allow_after_pop", 64'(issue_allow_o), 64'(1));
    repeat (3) tick();
    deq_ready_i = 0;
    chk("drained", 64'(count_o), 64'(0));

    // Flag accumulate with a same-cycle clear.
    issue(2);
    push($urandom, 5'b00001, 2'd2);
    push($urandom, 5'b10000, 2'd3);
    deq_ready_i = 1; tick();
    flags_clr_i = 1; tick();
    deq_ready_i = 0; flags_clr_i = 0;
    chk("flags_clr_same", 64'(flags_o), 64'(5'b10000));

    // Flush with a coincident push and issue.
    issue(3);
    push($urandom, 5'b00100, 2'd0);
    push($urandom, 5'b00100, 2'd1);
    flush_i = 1; fpu_valid_i = 1; issue_fire_i = 1; fpu_result_i = $urandom;
    tick();
    idle();
    chk("flush_count", 64'(count_o), 64'(0));
    chk("flush_valid", 64'(deq_valid_o), 64'(0));
    chk("flush_allow", 64'(issue_allow_o), 64'(1));
    chk("flush_flags", 64'(flags_o), 64'(5'b10000));

    for (int i = 0; i < 400; i++) rand_cycle();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 20; i++) rand_cycle();
    #2 rst_ni = 0;
    #1;
    chk("async_valid", 64'(deq_valid_o), 64'(0));
    chk("async_ready", 64'(fpu_ready_o), 64'(1));
    chk("async_allow", 64'(issue_allow_o), 64'(1));
    chk("async_count", 64'(count_o), 64'(0));
    chk("async_flags", 64'(flags_o), 64'(0));
    chk("async_ovf", 64'(overflow_o), 64'(0));
    idle();
    tick();
    rst_ni = 1;
    for (int i = 0; i < 200; i++) rand_cycle();

    // Drain whatever is still in flight.
    idle();
    deq_ready_i = 1;
    for (int i = 0; i < 20; i++) begin
      fpu_valid_i  = (m_cred - mq.size()) > 0;
      fpu_result_i = $urandom;
      fpu_tag_i    = TW'(i);
      tick();
    end
    idle();
    tick();
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
